wb_fill_engine: RTL and testbench
=================================

# wb_fill_engine

Wishbone B3 fill/DMA engine that writes a constant or incrementing 32-bit pattern to a word-aligned region, for clearing and painting the video buffers (0xFFFF0000, 0xFFFF4000) and initialising RAM without the CPU. It occupies the spare master slot (`masters[2]`) in front of the traffic cop. A small register file is exposed as a Wishbone slave behind the expander. Bursts are capped so the CPU masters are re-arbitrated regularly.

## Interface
- `MAX_BURST`, 16: beats per bus tenure before `cyc` is released; legal range 1..256.
- `COUNT_WIDTH`, 16: width of the word count and remaining count.
- `clk` in 1: Wishbone clock (`wb_clk`).
- `rst` in 1: reset, asynchronous, active-high.
- `cfg` `wishbone_b3.slave` interface: register access. Decode uses `adr[4:2]`; 32-bit data; `sel` ignored.
- `bus` `wishbone_b3.master` interface: fill write traffic.
- `irq` out 1: `ien & (done | err)`, level.

## Operation
- Register map (offsets):
  - 0x00 CTRL: [0] start (W1, self-clearing, reads 0); [1] abort (W1, self-clearing); [2] ien; [3] inc.
  - 0x04 STATUS (RO): [0] busy; [1] done; [2] err; [3] aborted.
  - 0x08 DST: bits [1:0] forced to 0.
  - 0x0C COUNT: words, [COUNT_WIDTH-1:0].
  - 0x10 PATTERN.
  - 0x14 REMAIN (RO).
  - Unmapped offsets read 0, writes are dropped, and all accesses are acked.
- While busy, writes to DST, COUNT, PATTERN and start are acked and ignored. The ien, inc and abort bits are always writable.
- On start:
  - Load cur_adr=DST, cur_dat=PATTERN, REMAIN=COUNT, beat=0.
  - Clear done, err and aborted; set busy.
  - COUNT=0: no bus cycle; done=1 and busy=0 on the next edge.
- FSM:
  - IDLE → BUS on start with COUNT≠0.
  - BUS: `cyc=stb=we=1`, `sel=4'hF`, `adr=cur_adr`, `dat_m2s=cur_dat`, `bte=2'b00`.
  - `cti=3'b111` when REMAIN==1 or beat==MAX_BURST-1; otherwise `cti=3'b010`.
  - On each edge with `ack` in BUS:
    - cur_adr+=4, wrapping mod 2^32.
    - cur_dat+=1 if inc, otherwise unchanged.
    - REMAIN-=1 and beat+=1.
  - After that acked beat, the next state is the first matching rule:
    - REMAIN becomes 0 → IDLE with done=1.
    - abort pending → IDLE with aborted=1.
    - beat reaches MAX_BURST → GAP with beat=0.
    - Otherwise stay in BUS.
  - `err` sampled in BUS: → IDLE with err=1. The errored beat does not count and REMAIN is not decremented. `err` takes precedence over `ack` in the same cycle.
  - `rty` is treated as no-ack: hold the beat.
  - GAP: `cyc=stb=0` for exactly one cycle, then → BUS.
  - Abort while in IDLE has no effect. Abort while in GAP → IDLE with aborted=1.
- Reset: FSM=IDLE; all registers 0; `cyc`, `stb`, `we`, `irq`, `cfg.ack` all 0; `cti`, `bte`, `sel`, `adr`, `dat_m2s` all 0.

## Timing
- `cfg` ack is registered:
  - An access is sampled on edge E while `cyc&stb&!ack`.
  - A write updates its register at E.
  - `ack` is high for the single cycle after E, together with read data.
- Start written at edge E: `bus.cyc` and `stb` are high in the cycle after E, concurrently with `cfg.ack`.
- Back-to-back beats: `adr` and `dat` update on the acking edge, with `stb` held high, for 1 beat/cycle against a zero-wait slave.
- Last beat acked at edge E: `cyc` and `stb` are low after E; busy=0 and done=1 are visible at E.
- `irq` is registered from status and ien, so it rises one cycle after done or err.
- Master outputs are all registered. No combinational path from `bus.ack` to master outputs.

## Structure
- Package `wb_fill_pkg` holds:
  - register offset constants;
  - CTRL and STATUS bit-index constants;
  - `typedef enum logic [1:0] {FILL_IDLE, FILL_BUS, FILL_GAP}`.
- Sub-module `wb_fill_regs`: the `cfg` slave, register file, start/abort pulse generation and status read-back. It exports a config bundle to the engine FSM in `wb_fill_engine`.

## Test plan
- DST=0xFFFF0000, COUNT=4, PATTERN=0x00FF00FF, ien=1, zero-wait slave:
  - adr 0xFFFF0000, 0x04, 0x08, 0x0C, each with data 0x00FF00FF;
  - cti 010, 010, 010, 111;
  - STATUS=0x2 and irq=1 one cycle later.
- COUNT=40, MAX_BURST=16:
  - `cyc` low for exactly one cycle after beats 16 and 32;
  - 40 acks, last adr DST+0x9C, REMAIN=0.
- inc=1, PATTERN=0xFFFFFFFE, COUNT=3: data 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Slave asserts `err` on beat 3 of COUNT=8:
  - `cyc` low the next cycle;
  - STATUS err=1, REMAIN=6.
- Slave stalls ack 5 cycles per beat; abort written during beat 2 of COUNT=10:
  - beat 2 completes, `cyc` drops;
  - aborted=1, REMAIN=8.
- COUNT=0 start gives no `cyc` and done=1 next edge. `rst` asserted mid-burst drops `cyc` and `stb` asynchronously and returns all registers to 0.

Source files
------------

// File: rtl/wb_fill_pkg.sv
// Shared constants and types for the Wishbone fill engine: register offsets
// (as adr[4:2] word indices), CTRL/STATUS bit positions, FSM states and the config bundle.
package wb_fill_pkg;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_DST     = 3'd2;
  localparam logic [2:0] REG_COUNT   = 3'd3;
  localparam logic [2:0] REG_PATTERN = 3'd4;
  localparam logic [2:0] REG_REMAIN  = 3'd5;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_IEN   = 2;
  localparam int CTRL_INC   = 3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERR     = 2;
  localparam int STAT_ABORTED = 3;

  typedef enum logic [1:0] {FILL_IDLE, FILL_BUS, FILL_GAP} fill_state_t;

  // start/abort are single-cycle pulses valid on the edge the CTRL write is sampled
  typedef struct packed {
    logic [31:0] dst;
    logic [31:0] pattern;
    logic        inc;
    logic        start;
    logic        abort;
  } fill_cfg_t;

endpackage

// File: rtl/wb_fill_regs.sv
// Wishbone slave register file for the fill engine: registered single-cycle ack,
// start/abort pulse generation and status read-back.
module wb_fill_regs
  import wb_fill_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_cfg_cyc,
  input  logic                   i_cfg_stb,
  input  logic                   i_cfg_we,
  input  logic [2:0]             i_cfg_adr,
  input  logic [31:0]            i_cfg_dat,
  output logic                   o_cfg_ack,
  output logic [31:0]            o_cfg_dat,
  input  logic                   i_busy,
  input  logic                   i_done,
  input  logic                   i_err,
  input  logic                   i_aborted,
  input  logic [COUNT_WIDTH-1:0] i_remain,
  output fill_cfg_t              o_cfg,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_ien
);

  logic                   r_ack;
  logic [31:0]            r_rdat;
  logic                   r_ien;
  logic                   r_inc;
  logic [31:0]            r_dst;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [31:0]            r_pattern;

  logic        w_access;
  logic        w_wr;
  logic        w_ctrl_wr;
  logic [31:0] w_rdata;

  // Valid/ready: an access is taken on any edge where cyc&stb is high and no ack is
  // outstanding; ack follows for exactly one cycle, so the master must drop stb on it.
  assign w_access  = i_cfg_cyc & i_cfg_stb & ~r_ack;
  assign w_wr      = w_access & i_cfg_we;
  assign w_ctrl_wr = w_wr & (i_cfg_adr == REG_CTRL);

  always_comb begin
    w_rdata = 32'd0;
    case (i_cfg_adr)
      REG_CTRL: begin
        w_rdata[CTRL_IEN] = r_ien;
        w_rdata[CTRL_INC] = r_inc;
      end
      REG_STATUS: begin
        w_rdata[STAT_BUSY]    = i_busy;
        w_rdata[STAT_DONE]    = i_done;
        w_rdata[STAT_ERR]     = i_err;
        w_rdata[STAT_ABORTED] = i_aborted;
      end
      REG_DST:     w_rdata = r_dst;
      REG_COUNT:   w_rdata = 32'(r_count);
      REG_PATTERN: w_rdata = r_pattern;
      REG_REMAIN:  w_rdata = 32'(i_remain);
      default:     w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack     <= 1'b0;
      r_rdat    <= 32'd0;
      r_ien     <= 1'b0;
      r_inc     <= 1'b0;
      r_dst     <= 32'd0;
      r_count   <= '0;
      r_pattern <= 32'd0;
    end else begin
      r_ack  <= w_access;
      r_rdat <= (w_access && !i_cfg_we) ? w_rdata : 32'd0;
      if (w_ctrl_wr) begin
        r_ien <= i_cfg_dat[CTRL_IEN];
        r_inc <= i_cfg_dat[CTRL_INC];
      end
      // Transfer parameters are frozen while a fill is in flight
      if (w_wr && !i_busy) begin
        case (i_cfg_adr)
          REG_DST:     r_dst     <= {i_cfg_dat[31:2], 2'b00};
          REG_COUNT:   r_count   <= i_cfg_dat[COUNT_WIDTH-1:0];
          REG_PATTERN: r_pattern <= i_cfg_dat;
          default:     ;
        endcase
      end
    end
  end

  always_comb begin
    o_cfg         = '0;
    o_cfg.dst     = r_dst;
    o_cfg.pattern = r_pattern;
    o_cfg.inc     = r_inc;
    o_cfg.start   = w_ctrl_wr & i_cfg_dat[CTRL_START] & ~i_busy;
    o_cfg.abort   = w_ctrl_wr & i_cfg_dat[CTRL_ABORT];
  end

  assign o_count   = r_count;
  assign o_ien     = r_ien;
  assign o_cfg_ack = r_ack;
  assign o_cfg_dat = r_rdat;

endmodule

// File: rtl/wb_fill_engine.sv
// Wishbone B3 fill master: writes a constant or incrementing word pattern to a
// word-aligned region in bursts of at most MAX_BURST beats, with a one-cycle gap between bursts.
module wb_fill_engine
  import wb_fill_pkg::*;
#(
  parameter int MAX_BURST   = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cfg_cyc,
  input  logic        i_cfg_stb,
  input  logic        i_cfg_we,
  input  logic [2:0]  i_cfg_adr,
  input  logic [31:0] i_cfg_dat,
  output logic        o_cfg_ack,
  output logic [31:0] o_cfg_dat,
  output logic        o_bus_cyc,
  output logic        o_bus_stb,
  output logic        o_bus_we,
  output logic [31:0] o_bus_adr,
  output logic [31:0] o_bus_dat,
  output logic [3:0]  o_bus_sel,
  output logic [2:0]  o_bus_cti,
  output logic [1:0]  o_bus_bte,
  input  logic        i_bus_ack,
  input  logic        i_bus_err,
  input  logic        i_bus_rty,
  output logic        irq,
  output logic [1:0]  o_state
);

  localparam logic [8:0]             LP_MAX  = 9'(MAX_BURST);
  localparam logic [8:0]             LP_LAST = 9'(MAX_BURST - 1);
  localparam logic [COUNT_WIDTH-1:0] LP_ONE  = COUNT_WIDTH'(1);

  fill_state_t            r_state;
  logic                   r_cyc, r_stb, r_we;
  logic [3:0]             r_sel;
  logic [2:0]             r_cti;
  logic [31:0]            r_adr, r_dat;
  logic [COUNT_WIDTH-1:0] r_remain;
  logic [8:0]             r_beat;
  logic                   r_busy, r_done, r_err, r_aborted;
  logic                   r_abort_pend, r_zero_pend, r_irq;

  fill_cfg_t              w_cfg;
  logic [COUNT_WIDTH-1:0] w_count;
  logic                   w_ien;
  logic                   w_ack;
  logic                   w_abort_now;
  logic [COUNT_WIDTH-1:0] w_remain_nx;
  logic [8:0]             w_beat_nx;

  wb_fill_regs #(.COUNT_WIDTH(COUNT_WIDTH)) u_regs (
    .clk       (clk),
    .rst       (rst),
    .i_cfg_cyc (i_cfg_cyc),
    .i_cfg_stb (i_cfg_stb),
    .i_cfg_we  (i_cfg_we),
    .i_cfg_adr (i_cfg_adr),
    .i_cfg_dat (i_cfg_dat),
    .o_cfg_ack (o_cfg_ack),
    .o_cfg_dat (o_cfg_dat),
    .i_busy    (r_busy),
    .i_done    (r_done),
    .i_err     (r_err),
    .i_aborted (r_aborted),
    .i_remain  (r_remain),
    .o_cfg     (w_cfg),
    .o_count   (w_count),
    .o_ien     (w_ien)
  );

  // cti for the beat being presented: end-of-burst on the last word or last beat of a tenure
  function automatic logic [2:0] f_cti(input logic [COUNT_WIDTH-1:0] rem, input logic [8:0] beat);
    f_cti = (rem == LP_ONE || beat == LP_LAST) ? 3'b111 : 3'b010;
  endfunction

  assign w_ack       = i_bus_ack & ~i_bus_rty;
  assign w_abort_now = r_abort_pend | w_cfg.abort;
  assign w_remain_nx = r_remain - LP_ONE;
  assign w_beat_nx   = r_beat + 9'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FILL_IDLE;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_sel        <= 4'h0;
      r_cti        <= 3'b000;
      r_adr        <= 32'd0;
      r_dat        <= 32'd0;
      r_remain     <= '0;
      r_beat       <= 9'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_zero_pend  <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_irq <= w_ien & (r_done | r_err);
      case (r_state)
        FILL_IDLE: begin
          if (r_zero_pend) begin
            r_zero_pend <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end else if (w_cfg.start) begin
            r_adr        <= w_cfg.dst;
            r_dat        <= w_cfg.pattern;
            r_remain     <= w_count;
            r_beat       <= 9'd0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_busy       <= 1'b1;
            if (w_count == '0) begin
              r_zero_pend <= 1'b1;
            end else begin
              r_state <= FILL_BUS;
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_we    <= 1'b1;
              r_sel   <= 4'hF;
              r_cti   <= f_cti(w_count, 9'd0);
            end
          end
        end
        FILL_BUS: begin
          if (i_bus_err) begin
            r_state <= FILL_IDLE;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else if (w_ack) begin
            r_adr    <= r_adr + 32'd4;
            r_dat    <= w_cfg.inc ? r_dat + 32'd1 : r_dat;
            r_remain <= w_remain_nx;
            r_beat   <= w_beat_nx;
            if (w_remain_nx == '0 || w_abort_now) begin
              r_state   <= FILL_IDLE;
              r_cyc     <= 1'b0;
              r_stb     <= 1'b0;
              r_we      <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= (w_remain_nx == '0);
              r_aborted <= (w_remain_nx != '0);
            end else if (w_beat_nx == LP_MAX) begin
              r_state <= FILL_GAP;
              r_cyc   <= 1'b0;
              r_stb   <= 1'b0;
              r_we    <= 1'b0;
              r_beat  <= 9'd0;
            end else begin
              r_cti <= f_cti(w_remain_nx, w_beat_nx);
            end
          end else if (w_cfg.abort) begin
            r_abort_pend <= 1'b1;
          end
        end
        FILL_GAP: begin
          if (w_cfg.abort) begin
            r_state   <= FILL_IDLE;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
          end else begin
            r_state <= FILL_BUS;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= 1'b1;
            r_cti   <= f_cti(r_remain, 9'd0);
          end
        end
        default: r_state <= FILL_IDLE;
      endcase
    end
  end

  assign o_bus_cyc = r_cyc;
  assign o_bus_stb = r_stb;
  assign o_bus_we  = r_we;
  assign o_bus_adr = r_adr;
  assign o_bus_dat = r_dat;
  assign o_bus_sel = r_sel;
  assign o_bus_cti = r_cti;
  assign o_bus_bte = 2'b00;
  assign irq       = r_irq;
  assign o_state   = r_state;

endmodule

// File: tb/tb_wb_fill_engine.sv
// Directed and randomised fills against a behavioural Wishbone slave with a
// beat-list reference model of the expected write traffic.
module tb_wb_fill_engine;

  localparam int MAXB = 16;
  localparam int CW   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_cyc = 1'b0, cfg_stb = 1'b0, cfg_we = 1'b0;
  logic [2:0]  cfg_adr = 3'd0;
  logic [31:0] cfg_dat_w = 32'd0;
  logic        cfg_ack;
  logic [31:0] cfg_dat_r;
  logic        bus_cyc, bus_stb, bus_we;
  logic [31:0] bus_adr, bus_dat;
  logic [3:0]  bus_sel;
  logic [2:0]  bus_cti;
  logic [1:0]  bus_bte;
  logic        bus_ack = 1'b0, bus_err = 1'b0, bus_rty = 1'b0;
  logic        irq;
  logic [1:0]  state;

  always #5 clk = ~clk;

  wb_fill_engine #(.MAX_BURST(MAXB), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .i_cfg_cyc(cfg_cyc), .i_cfg_stb(cfg_stb), .i_cfg_we(cfg_we),
    .i_cfg_adr(cfg_adr), .i_cfg_dat(cfg_dat_w),
    .o_cfg_ack(cfg_ack), .o_cfg_dat(cfg_dat_r),
    .o_bus_cyc(bus_cyc), .o_bus_stb(bus_stb), .o_bus_we(bus_we),
    .o_bus_adr(bus_adr), .o_bus_dat(bus_dat), .o_bus_sel(bus_sel),
    .o_bus_cti(bus_cti), .o_bus_bte(bus_bte),
    .i_bus_ack(bus_ack), .i_bus_err(bus_err), .i_bus_rty(bus_rty),
    .irq(irq), .o_state(state)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_adr_q[$], obs_adr_q[$], exp_dat_q[$], obs_dat_q[$];
  logic [31:0] exp_cti_q[$], obs_cti_q[$], exp_gap_q[$], obs_gap_q[$];

  int   wait_cycles = 0, wcnt = 0, n_acked = 0, err_at = -1, low_cnt = 0;
  logic err_prev = 1'b0, cyc_after_err = 1'b1, cyc_at_ack = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural slave: decides ack/err on the falling edge, logging each accepted beat
  always @(negedge clk) begin
    if (rst) begin
      bus_ack = 1'b0; bus_err = 1'b0; wcnt = 0; err_prev = 1'b0;
    end else begin
      if (err_prev) begin
        cyc_after_err = bus_cyc;
        err_prev = 1'b0;
      end
      bus_ack = 1'b0;
      bus_err = 1'b0;
      if (!bus_cyc) begin
        low_cnt++;
      end else if (bus_stb) begin
        if (wcnt < wait_cycles) begin
          wcnt++;
        end else begin
          wcnt = 0;
          if (n_acked == err_at) begin
            bus_err = 1'b1;
            err_prev = 1'b1;
          end else begin
            bus_ack = 1'b1;
            obs_adr_q.push_back(bus_adr);
            obs_dat_q.push_back(bus_dat);
            obs_cti_q.push_back(32'(bus_cti));
            obs_gap_q.push_back((n_acked == 0) ? 32'd0 : 32'(low_cnt));
            low_cnt = 0;
            n_acked++;
          end
        end
      end
    end
  end

  task automatic cfg_access(input logic we, input logic [2:0] a, input logic [31:0] d,
                            output logic [31:0] rd);
    logic got;
    got = 1'b0;
    @(negedge clk);
    cfg_cyc = 1'b1; cfg_stb = 1'b1; cfg_we = we; cfg_adr = a; cfg_dat_w = d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cfg_ack) begin got = 1'b1; break; end
    end
    rd = cfg_dat_r;
    cyc_at_ack = bus_cyc;
    cfg_cyc = 1'b0; cfg_stb = 1'b0; cfg_we = 1'b0;
    chk("cfg_ack", 32'(got), 32'd1);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    cfg_access(1'b1, a, d, unused_rd);
  endtask

  task automatic cfg_read_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    cfg_access(1'b0, a, 32'd0, rd);
    chk(tag, rd, exp);
  endtask

  // Reference: beat i writes dst+4i with pattern(+i); end-of-burst on last word or
  // every MAXB-th beat; one idle cycle precedes each new tenure.
  task automatic build_exp(input logic [31:0] dst, input int count, input logic [31:0] pat,
                           input bit inc, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      exp_adr_q.push_back(dst + 32'(4 * i));
      exp_dat_q.push_back(inc ? pat + 32'(i) : pat);
      exp_cti_q.push_back((i == count - 1 || (i % MAXB) == MAXB - 1) ? 32'd7 : 32'd2);
      exp_gap_q.push_back((i != 0 && (i % MAXB) == 0) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic start_fill(input logic [31:0] dst_raw, input int count, input logic [31:0] pat,
                            input bit inc, input int wt, input int nbeats);
    logic [31:0] dst;
    dst = {dst_raw[31:2], 2'b00};
    exp_adr_q.delete(); obs_adr_q.delete(); exp_dat_q.delete(); obs_dat_q.delete();
    exp_cti_q.delete(); obs_cti_q.delete(); exp_gap_q.delete(); obs_gap_q.delete();
    n_acked = 0; wcnt = 0; wait_cycles = wt;
    build_exp(dst, count, pat, inc, nbeats);
    cfg_write(3'd2, dst_raw);
    cfg_read_chk("dst_align", 3'd2, dst);
    cfg_write(3'd3, 32'(count));
    cfg_write(3'd4, pat);
    cfg_write(3'd0, 32'h5 | (inc ? 32'h8 : 32'h0));
    chk("start_cyc", 32'(cyc_at_ack), (count != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state == 2'd0 && !bus_cyc) begin ok = 1'b1; break; end
    end
    chk("idle_wait", 32'(ok), 32'd1);
  endtask

  task automatic finish_check(input string tag, input logic [31:0] exp_status,
                              input logic [31:0] exp_remain);
    wait_idle(2000);
    chk({tag, "_nbeats"}, 32'(obs_adr_q.size()), 32'(exp_adr_q.size()));
    for (int i = 0; i < exp_adr_q.size() && i < obs_adr_q.size(); i++) begin
      chk($sformatf("%s_adr%0d", tag, i), obs_adr_q[i], exp_adr_q[i]);
      chk($sformatf("%s_dat%0d", tag, i), obs_dat_q[i], exp_dat_q[i]);
      chk($sformatf("%s_cti%0d", tag, i), obs_cti_q[i], exp_cti_q[i]);
      chk($sformatf("%s_gap%0d", tag, i), obs_gap_q[i], exp_gap_q[i]);
    end
    cfg_read_chk({tag, "_status"}, 3'd1, exp_status);
    cfg_read_chk({tag, "_remain"}, 3'd5, exp_remain);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r_dst, r_pat;
    int          r_cnt;
    bit          r_inc;
    bit          ok;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(bus_cyc), 32'd0);
    chk("rst_stb", 32'(bus_stb), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_adr", bus_adr, 32'd0);
    chk("rst_dat", bus_dat, 32'd0);
    chk("rst_sel", 32'(bus_sel), 32'd0);
    chk("rst_cti", 32'(bus_cti), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_cfg_ack", 32'(cfg_ack), 32'd0);
    rst = 1'b0;
    cfg_read_chk("rst_status", 3'd1, 32'd0);
    cfg_read_chk("unmapped6", 3'd6, 32'd0);
    cfg_write(3'd7, 32'hFFFF_FFFF);
    cfg_read_chk("unmapped7", 3'd7, 32'd0);

    // Video buffer clear, 4 words, irq one cycle after done
    start_fill(32'hFFFF_0000, 4, 32'h00FF_00FF, 1'b0, 0, 4);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus_cyc) begin ok = 1'b1; break; end
    end
    chk("t1_cyc_drop", 32'(ok), 32'd1);
    chk("t1_irq_lag", 32'(irq), 32'd0);
    @(negedge clk);
    chk("t1_irq", 32'(irq), 32'd1);
    finish_check("t1", 32'h2, 32'd0);

    // Multi-burst fill; PATTERN write while busy is dropped
    start_fill(32'h0000_1000, 40, 32'h1234_5678, 1'b0, 0, 40);
    cfg_write(3'd4, 32'hDEAD_BEEF);
    finish_check("t2", 32'h2, 32'd0);
    cfg_read_chk("t2_pat_kept", 3'd4, 32'h1234_5678);

    // Incrementing data wraps mod 2^32
    start_fill(32'h0000_2000, 3, 32'hFFFF_FFFE, 1'b1, 0, 3);
    finish_check("t3", 32'h2, 32'd0);

    // Bus error on the third beat
    err_at = 2;
    cyc_after_err = 1'b1;
    start_fill(32'h0000_3000, 8, 32'hA5A5_0000, 1'b1, 0, 2);
    finish_check("t4", 32'h4, 32'd6);
    err_at = -1;
    chk("t4_cyc_after_err", 32'(cyc_after_err), 32'd0);
    chk("t4_irq", 32'(irq), 32'd1);

    // Abort during the second beat against a stalling slave
    start_fill(32'h0000_4000, 10, 32'h0000_0077, 1'b0, 5, 2);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_acked >= 1) begin ok = 1'b1; break; end
    end
    chk("t5_first_beat", 32'(ok), 32'd1);
    cfg_write(3'd0, 32'h6);
    finish_check("t5", 32'h8, 32'd8);
    chk("t5_irq", 32'(irq), 32'd0);
    wait_cycles = 0;

    // Zero-length fill
    start_fill(32'h0000_5000, 0, 32'h1111_1111, 1'b0, 0, 0);
    finish_check("t6", 32'h2, 32'd0);

    // Randomised fills
    for (int k = 0; k < 4; k++) begin
      r_dst = $urandom;
      r_pat = $urandom;
      r_cnt = $urandom_range(1, 40);
      r_inc = 1'($urandom_range(0, 1));
      start_fill(r_dst, r_cnt, r_pat, r_inc, $urandom_range(0, 2), r_cnt);
      finish_check($sformatf("rnd%0d", k), 32'h2, 32'd0);
    end
    wait_cycles = 0;

    // Asynchronous reset mid-burst
    start_fill(32'h0000_6000, 40, 32'h5555_AAAA, 1'b1, 0, 40);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_acked >= 5) begin ok = 1'b1; break; end
    end
    chk("t7_midburst", 32'(ok), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t7_async_cyc", 32'(bus_cyc), 32'd0);
    chk("t7_async_stb", 32'(bus_stb), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("t7_state", 32'(state), 32'd0);
    chk("t7_irq", 32'(irq), 32'd0);
    cfg_read_chk("t7_ctrl", 3'd0, 32'd0);
    cfg_read_chk("t7_status", 3'd1, 32'd0);
    cfg_read_chk("t7_dst", 3'd2, 32'd0);
    cfg_read_chk("t7_count", 3'd3, 32'd0);
    cfg_read_chk("t7_pattern", 3'd4, 32'd0);
    cfg_read_chk("t7_remain", 3'd5, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
